// File: rtl/hamiltonian_calc.sv
// hamiltonian_calc
// Buffers the signed partial sum of each array row as the row sequencer saves
// it, then on a rising edge of cal_H sums every valid row into a Hamiltonian.
// Each completed result is published on h_value with a one-cycle cal_done
// pulse. The minimum result since the last best_clr is tracked, along with
// a saturating count of completed calculations.
//
// Ports
//   clk, resetb    clock, synchronous active-low reset
//   sample_trig    new sample: clears row valid mask, aborts a summation
//   row_number     row address for save
//   save, row_sum  capture strobe and signed row partial sum
//   cal_H          calculate request (level, rising edge starts)
//   best_clr       clears best tracking and the sample counter
//   cal_done       one-cycle pulse when h_value is updated
//   h_value        signed Hamiltonian of last completed calculation
//   h_valid        h_value holds a completed result
//   best_h         signed minimum h_value since best_clr
//   best_valid     best_h is meaningful
//   sample_count   completed calculations since best_clr (saturating)
//   busy           state is SUM or DONE
//   state          present state encoding (IDLE=0, SUM=1, DONE=2)
module hamiltonian_calc #(
  parameter int NUM_ROW = 46,
  parameter int ROW_W   = 12,
  parameter int ACC_W   = ROW_W + $clog2(NUM_ROW),
  parameter int CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic                             sample_trig,
  input  logic [$clog2(NUM_ROW)-1:0]       row_number,
  input  logic                             save,
  input  logic signed [ROW_W-1:0]          row_sum,
  input  logic                             cal_H,
  input  logic                             best_clr,
  output logic                             cal_done,
  output logic signed [ACC_W-1:0]          h_value,
  output logic                             h_valid,
  output logic signed [ACC_W-1:0]          best_h,
  output logic                             best_valid,
  output logic [CNT_W-1:0]                 sample_count,
  output logic                             busy,
  output logic [1:0]                       state
);

  localparam int RN_W = $clog2(NUM_ROW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic signed [ACC_W-1:0] sign_ext(input logic signed [ROW_W-1:0] v);
    return ACC_W'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_cal_H_q;
  logic [NUM_ROW-1:0]        r_valid;
  logic signed [ROW_W-1:0]   r_buf [NUM_ROW];
  logic signed [ACC_W-1:0]   r_acc;
  logic [RN_W-1:0]           r_idx;
  logic                      r_cal_done;
  logic signed [ACC_W-1:0]   r_h_value;
  logic                      r_h_valid;
  logic signed [ACC_W-1:0]   r_best_h;
  logic                      r_best_valid;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_start;
  logic                      w_last;
  logic                      w_wr;
  logic signed [ACC_W-1:0]   w_addend;

  assign w_start  = cal_H & ~r_cal_H_q;
  assign w_last   = (32'(r_idx) == NUM_ROW - 1);
  // A save coinciding with sample_trig belongs to the aborted sample.
  assign w_wr     = save & ~sample_trig & (32'(row_number) < NUM_ROW);
  // Rows never saved this sample contribute zero, not stale buffer contents.
  assign w_addend = r_valid[r_idx] ? sign_ext(r_buf[r_idx]) : '0;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start && !sample_trig) w_next = S_SUM;
      S_SUM: begin
        if (sample_trig)  w_next = S_IDLE;
        else if (w_last)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- row buffer (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[row_number] <= row_sum;
  end

  // ---- control, accumulator and result registers ----
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_cal_H_q    <= 1'b0;
      r_valid      <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_cal_done   <= 1'b0;
      r_h_value    <= '0;
      r_h_valid    <= 1'b0;
      r_best_h     <= '0;
      r_best_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_cal_H_q  <= cal_H;
      r_cal_done <= 1'b0;

      if (sample_trig)  r_valid <= '0;
      else if (w_wr)    r_valid[row_number] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start && !sample_trig) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_SUM: begin
          if (!sample_trig) begin
            r_acc <= r_acc + w_addend;
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (!sample_trig) begin
            r_h_value  <= r_acc;
            r_h_valid  <= 1'b1;
            r_cal_done <= 1'b1;
            if (!r_best_valid || (r_acc < r_best_h)) begin
              r_best_h     <= r_acc;
              r_best_valid <= 1'b1;
            end
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: ;
      endcase

      // Clear takes priority over a same-cycle DONE best/count update.
      if (best_clr) begin
        r_best_valid <= 1'b0;
        r_best_h     <= '0;
        r_cnt        <= '0;
      end
    end
  end

  assign cal_done     = r_cal_done;
  assign h_value      = r_h_value;
  assign h_valid      = r_h_valid;
  assign best_h       = r_best_h;
  assign best_valid   = r_best_valid;
  assign sample_count = r_cnt;
  assign busy         = (r_state == S_SUM) || (r_state == S_DONE);
  assign state        = r_state;

endmodule

// File: tb/tb_hamiltonian_calc.sv
// Directed bench for hamiltonian_calc: a 4-row instance exercises the
// sequencing behaviour, a 46-row instance covers the full-scale sum.
module tb_hamiltonian_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb, sample_trig, cal_H, best_clr;
  logic [1:0]         rn4;
  logic               save4;
  logic signed [11:0] rs4;
  logic [5:0]         rn46;
  logic               save46;
  logic signed [11:0] rs46;

  logic               done4, hval4, bv4, busy4;
  logic signed [13:0] hv4, bh4;
  logic [15:0]        cnt4;
  logic [1:0]         st4;

  logic               done46, hval46, bv46, busy46;
  logic signed [17:0] hv46, bh46;
  logic [15:0]        cnt46;
  logic [1:0]         st46;

  hamiltonian_calc #(.NUM_ROW(4), .ROW_W(12), .CNT_W(16)) u4 (
    .clk(clk), .resetb(resetb), .sample_trig(sample_trig), .row_number(rn4),
    .save(save4), .row_sum(rs4), .cal_H(cal_H), .best_clr(best_clr),
    .cal_done(done4), .h_value(hv4), .h_valid(hval4), .best_h(bh4),
    .best_valid(bv4), .sample_count(cnt4), .busy(busy4), .state(st4));

  hamiltonian_calc #(.NUM_ROW(46), .ROW_W(12), .CNT_W(16)) u46 (
    .clk(clk), .resetb(resetb), .sample_trig(sample_trig), .row_number(rn46),
    .save(save46), .row_sum(rs46), .cal_H(cal_H), .best_clr(best_clr),
    .cal_done(done46), .h_value(hv46), .h_valid(hval46), .best_h(bh46),
    .best_valid(bv46), .sample_count(cnt46), .busy(busy46), .state(st46));

  int n_chk = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic save_row4(input logic [1:0] r, input logic signed [11:0] v);
    rn4 = r; rs4 = v; save4 = 1'b1;
    tick();
    save4 = 1'b0;
  endtask

  // Cycles from the current point until done4 is seen; -1 on timeout.
  task automatic wait_done4(output int lat);
    bit seen;
    lat = -1;
    seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      tick();
      if (done4) begin
        lat = c;
        seen = 1'b1;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    bit seen;
    resetb = 1'b0; sample_trig = 1'b0; cal_H = 1'b0; best_clr = 1'b0;
    rn4 = '0; save4 = 1'b0; rs4 = '0;
    rn46 = '0; save46 = 1'b0; rs46 = '0;
    tick(); tick();
    chk("rst_h_value", hv4, 0);
    chk("rst_h_valid", hval4, 0);
    chk("rst_best_valid", bv4, 0);
    chk("rst_count", cnt4, 0);
    chk("rst_state", st4, 0);
    chk("rst_cal_done", done4, 0);
    resetb = 1'b1;
    tick();

    // Basic sum: 5 - 3 + 7 - 20 = -11
    save_row4(2'd0, 12'sd5);
    save_row4(2'd1, -12'sd3);
    save_row4(2'd2, 12'sd7);
    save_row4(2'd3, -12'sd20);
    cal_H = 1'b1;
    wait_done4(lat);
    chk("t1_latency", lat, 6);
    chk("t1_h_value", hv4, -11);
    chk("t1_h_valid", hval4, 1);
    chk("t1_best_h", bh4, -11);
    chk("t1_best_valid", bv4, 1);
    chk("t1_count", cnt4, 1);

    // Held cal_H: no retrigger, cal_done is a single-cycle pulse
    pulses = 0;
    repeat (10) begin
      tick();
      if (done4) pulses++;
    end
    chk("t2_extra_pulses", pulses, 0);
    chk("t2_count", cnt4, 1);
    cal_H = 1'b0;
    tick();

    // best_clr outside DONE
    best_clr = 1'b1;
    tick();
    best_clr = 1'b0;
    chk("clr_best_valid", bv4, 0);
    chk("clr_best_h", bh4, 0);
    chk("clr_count", cnt4, 0);
    chk("clr_h_kept", hv4, -11);

    // Only rows 1 and 3 valid: 4 + 2 = 6
    sample_trig = 1'b1;
    tick();
    sample_trig = 1'b0;
    save_row4(2'd1, 12'sd4);
    save_row4(2'd3, 12'sd2);
    cal_H = 1'b1;
    wait_done4(lat);
    cal_H = 1'b0;
    chk("t3_latency", lat, 6);
    chk("t3_h_value", hv4, 6);
    chk("t3_best_h", bh4, 6);

    // Save in the sample_trig cycle is dropped; rows 1..3 give 50
    rn4 = 2'd0; rs4 = 12'sd100; save4 = 1'b1; sample_trig = 1'b1;
    tick();
    save4 = 1'b0; sample_trig = 1'b0;
    save_row4(2'd1, 12'sd20);
    save_row4(2'd2, 12'sd15);
    save_row4(2'd3, 12'sd15);
    cal_H = 1'b1;
    wait_done4(lat);
    cal_H = 1'b0;
    chk("t3b_h_value", hv4, 50);
    chk("t3b_best_h", bh4, 6);
    chk("t3b_count", cnt4, 2);
    tick();

    // sample_trig during SUM aborts the calculation
    cal_H = 1'b1;
    tick();
    chk("t4_state_sum", st4, 1);
    chk("t4_busy", busy4, 1);
    tick();
    sample_trig = 1'b1;
    tick();
    sample_trig = 1'b0; cal_H = 1'b0;
    chk("t4_state_idle", st4, 0);
    chk("t4_busy_idle", busy4, 0);
    pulses = 0;
    repeat (8) begin
      tick();
      if (done4) pulses++;
    end
    chk("t4_no_done", pulses, 0);
    chk("t4_h_kept", hv4, 50);
    chk("t4_count_kept", cnt4, 2);
    save_row4(2'd0, -12'sd1);
    save_row4(2'd1, -12'sd2);
    save_row4(2'd2, -12'sd3);
    save_row4(2'd3, -12'sd4);
    cal_H = 1'b1;
    wait_done4(lat);
    cal_H = 1'b0;
    chk("t4_latency", lat, 6);
    chk("t4_h_value", hv4, -10);
    chk("t4_best_h", bh4, -10);
    chk("t4_count", cnt4, 3);

    // best_clr in the DONE cycle: -1 - 2 + 30 - 4 = 23
    save_row4(2'd2, 12'sd30);
    cal_H = 1'b1;
    tick();
    repeat (4) tick();
    chk("t5_state_done", st4, 2);
    best_clr = 1'b1;
    tick();
    best_clr = 1'b0; cal_H = 1'b0;
    chk("t5_cal_done", done4, 1);
    chk("t5_h_value", hv4, 23);
    chk("t5_best_valid", bv4, 0);
    chk("t5_count", cnt4, 0);
    tick();
    chk("t5_done_drop", done4, 0);
    save_row4(2'd2, 12'sd0);
    cal_H = 1'b1;
    wait_done4(lat);
    cal_H = 1'b0;
    chk("t5b_h_value", hv4, -7);
    chk("t5b_best_h", bh4, -7);
    chk("t5b_best_valid", bv4, 1);
    chk("t5b_count", cnt4, 1);
    tick();

    // Reset in the middle of SUM
    cal_H = 1'b1;
    tick(); tick();
    resetb = 1'b0;
    tick();
    resetb = 1'b1; cal_H = 1'b0;
    chk("t6_h_value", hv4, 0);
    chk("t6_h_valid", hval4, 0);
    chk("t6_best_h", bh4, 0);
    chk("t6_best_valid", bv4, 0);
    chk("t6_count", cnt4, 0);
    chk("t6_state", st4, 0);
    chk("t6_busy", busy4, 0);
    pulses = 0;
    repeat (8) begin
      tick();
      if (done4) pulses++;
    end
    chk("t6_no_done", pulses, 0);

    // Full scale on 46 rows: 46 * -2048 = -94208; out-of-range row ignored
    for (int r = 0; r < 46; r++) begin
      rn46 = 6'(r); rs46 = -12'sd2048; save46 = 1'b1;
      tick();
    end
    rn46 = 6'd50; rs46 = 12'sd1000; save46 = 1'b1;
    tick();
    save46 = 1'b0;
    cal_H = 1'b1;
    lat = -1;
    seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      tick();
      if (done46) begin
        lat = c;
        seen = 1'b1;
      end
    end
    cal_H = 1'b0;
    chk("fs_latency", lat, 48);
    chk("fs_h_value", hv46, -94208);
    chk("fs_best_h", bh46, -94208);
    chk("fs_count", cnt46, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
